// File: rtl/axi_bus_pkg.sv
// Shared AXI read-side bus types and sizing.
// Global read ID is {master index, local id}.
package axi_bus_pkg;

  localparam int NUM_MASTERS   = 4;
  localparam int NUM_U_READS   = 4;
  localparam int MID_W         = $clog2(NUM_MASTERS);
  localparam int ARID          = 2;
  localparam int RID           = 2;
  localparam int RID_MID       = MID_W + RID;
  localparam int OUTSTANDING_W = $clog2(NUM_U_READS + 1);
  localparam int AW            = 32;
  localparam int DW            = 32;

  typedef logic [MID_W-1:0] mid_t;

  typedef struct packed {
    logic               valid;
    logic               ready;
    logic [AW-1:0]      addr;
    logic [ARID-1:0]    id;
    logic [RID_MID-1:0] mid_id;
    logic [2:0]         size;
    logic [7:0]         len;
    logic [1:0]         burst;
  } ar_channel_t;

  typedef struct packed {
    logic               valid;
    logic [DW-1:0]      data;
    logic               last;
    logic [1:0]         resp;
    logic [RID-1:0]     id;
    logic [RID_MID-1:0] mid_id;
  } r_channel_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i
// and wraps; first requester wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    any_o = |req_i;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-side AR arbiter with per-master credits and
// combinational R routing by global ID.
module axi_read_arbiter
  import axi_bus_pkg::*;
(
  input  logic                                      CLK,
  input  logic                                      nRST,
  input  ar_channel_t [NUM_MASTERS-1:0]             m_ar,
  output logic        [NUM_MASTERS-1:0]             m_ar_ready,
  output ar_channel_t                               s_ar,
  input  logic                                      s_ar_ready,
  input  r_channel_t                                s_r,
  output logic                                      s_r_ready,
  output r_channel_t  [NUM_MASTERS-1:0]             m_r,
  input  logic        [NUM_MASTERS-1:0]             m_r_ready,
  output logic [NUM_MASTERS-1:0][OUTSTANDING_W-1:0] outstanding
);

  slot_state_e state_q, state_d;
  ar_channel_t slot_q, slot_d;
  mid_t        rr_q, rr_d;

  logic [NUM_MASTERS-1:0][OUTSTANDING_W-1:0] cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] elig, gnt, inc, dec;
  mid_t                   gnt_idx, dst;
  logic                   any, load, r_hs;

  logic [NUM_MASTERS-1:0] unused_ar;
  logic                   unused_rid;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = m_ar[i].valid &&
        (cnt_q[i] < OUTSTANDING_W'(NUM_U_READS));
    end
  end

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req_i (elig),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any)
  );

  // Gated by nRST so no master sees an accept while in reset.
  assign load = nRST && any &&
    ((state_q == SLOT_EMPTY) || s_ar_ready);

  assign m_ar_ready = load ? gnt : '0;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    rr_d    = rr_q;
    unique case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL:  if (s_ar_ready && !load) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
    if (load) begin
      slot_d        = m_ar[gnt_idx];
      slot_d.ready  = 1'b0;
      slot_d.mid_id = {gnt_idx, m_ar[gnt_idx].id};
      rr_d          = gnt_idx + mid_t'(1);
    end
    slot_d.valid = (state_d == SLOT_FULL);
  end

  assign r_hs = s_r.valid && s_r_ready;
  assign dst  = s_r.mid_id[RID_MID-1:RID];

  always_comb begin
    inc   = '0;
    dec   = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      inc[i] = load && gnt[i];
      dec[i] = r_hs && s_r.last && (dst == mid_t'(i)) &&
        (cnt_q[i] != '0);
      unique case ({inc[i], dec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + OUTSTANDING_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - OUTSTANDING_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= SLOT_EMPTY;
      slot_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_ar        = slot_q;
  assign outstanding = cnt_q;

  always_comb begin
    m_r = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_r[i]       = s_r;
      m_r[i].valid = s_r.valid && (dst == mid_t'(i));
      m_r[i].id    = s_r.mid_id[RID-1:0];
    end
  end

  assign s_r_ready = m_r_ready[dst];

  always_comb begin
    unused_ar = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      unused_ar[i] = m_ar[i].ready ^ (^m_ar[i].mid_id);
    end
  end
  assign unused_rid = ^s_r.id;

  // A last beat for a master with no credit out is a protocol error.
  ast_no_underflow: assert property (
    @(posedge CLK) disable iff (!nRST)
    (r_hs && s_r.last) |-> (cnt_q[dst] != '0)
  );

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Read-side AXI interconnect arbiter that shares the single downstream AR/R port between the four bus masters (I$, D$, SP0, SP1). It round-robins AR requests from masters that still hold read credits, registers the winner, and tags it with a global ID of `{master ID, local id}`. It also routes R beats back to the owning master by decoding that global ID. It sits between the master ports and the memory-side slave, and enforces the per-master outstanding-read budget.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesters; index equals `mid_t` value.
- NUM_U_READS, 4, maximum outstanding reads per master.

Ports:
- CLK  in  1  system clock; single clock domain.
- nRST  in  1  asynchronous, active-low reset.
- m_ar  in  ar_channel_t [NUM_MASTERS]  master AR requests; uses valid, addr, id, size, len, burst; ready and mid_id fields ignored.
- m_ar_ready  out  [NUM_MASTERS]  per-master AR accept.
- s_ar  out  ar_channel_t  downstream AR; mid_id = {master index, id}; ready field driven 0.
- s_ar_ready  in  1  downstream AR accept.
- s_r  in  r_channel_t  downstream R beat (valid, data, last, resp, mid_id).
- s_r_ready  out  1  R accept to slave.
- m_r  out  r_channel_t [NUM_MASTERS]  R beats to masters; id = mid_id[RID-1:0].
- m_r_ready  in  [NUM_MASTERS]  master R accept.
- outstanding  out  [NUM_MASTERS][$clog2(NUM_U_READS+1)]  per-master credit counters, for debug.

## Operation
- Eligibility: master i is eligible when m_ar[i].valid is high and outstanding[i] < NUM_U_READS.
- Round-robin arbitration:
  - Pointer rr_ptr (2 bits).
  - Search starts at rr_ptr and wraps modulo NUM_MASTERS.
  - The first eligible master wins.
- Output slot: one register holding s_ar. Two states:
  - EMPTY: s_ar.valid=0.
  - FULL: s_ar.valid=1.
- Load condition: load = any eligible && (EMPTY || s_ar_ready).
  - On load: m_ar_ready[winner]=1 in the same cycle; slot captures the winner's fields plus mid_id={winner, id}.
  - On load: rr_ptr ← winner+1 (wraps 3→0).
- Transitions:
  - EMPTY→FULL on load.
  - FULL→EMPTY on s_ar_ready with no load.
  - FULL→FULL on s_ar_ready with load (back-to-back, 1 AR/cycle).
  - FULL→FULL with the slot held stable while s_ar_ready=0.
- Fields are never changed while s_ar.valid=1 and s_ar_ready=0.
- Credits:
  - outstanding[i] increments when master i is loaded.
  - outstanding[i] decrements on an R handshake (s_r.valid && s_r_ready) with last=1 and mid_id[RID_MID-1:RID]==i.
  - Simultaneous inc and dec on the same master leaves the count unchanged.
  - A master at NUM_U_READS is masked until a last beat returns.
  - Counts never underflow; an unmatched last is a protocol error and is checked only by assertion.
- R routing is combinational:
  - Destination d = s_r.mid_id[RID_MID-1:RID].
  - m_r[d].valid = s_r.valid; all other m_r valids are 0.
  - s_r_ready = m_r_ready[d].
  - data, last, resp and mid_id are broadcast to all masters.

## Timing
- Reset values:
  - s_ar all fields 0.
  - m_ar_ready 0.
  - rr_ptr 0 (ICACHE first).
  - outstanding all 0.
  - m_r valids 0 (s_r.valid is low in reset).
- AR latency: 1 cycle from master handshake to s_ar.valid.
- Throughput: one AR per cycle while s_ar_ready stays high.
- R path: 0 cycles. There is a comb path s_r→m_r and m_r_ready→s_r_ready.
- m_ar_ready depends combinationally on m_ar valids, outstanding, slot state and s_ar_ready.
- Reset mid-operation: the slot and counters clear immediately. In-flight transactions are discarded; the system resets all masters and the slave together.

## Structure
- Package axi_bus_pkg holds:
  - ar_channel_t, r_channel_t, mid_t.
  - NUM_MASTERS, NUM_U_READS, ARID, RID, RID_MID.
- Add to the package: OUTSTANDING_W = $clog2(NUM_U_READS+1).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant, grant index, any.
  - Combinational; reused later by the write-side arbiter.

## Test plan
- Reset, then D$ AR addr=0x1000 id=2 → next cycle s_ar.valid=1, addr=0x1000, mid_id=4'b0110; outstanding[1]=1.
- All four masters valid continuously, s_ar_ready=1 → grant order 0,1,2,3,0 on consecutive cycles; one s_ar per cycle.
- s_ar_ready=0 for 5 cycles with FULL slot → s_ar fields stable; every m_ar_ready=0.
- SP0 issues 4 ARs, no R returned → fifth request stalls (m_ar_ready[2]=0) while others are still granted. One R with last and mid_id=4'b10xx → SP0 accepted the next cycle.
- R beat with mid_id=4'b0011, m_r_ready[0]=0 → m_r[0].valid=1, others 0, s_r_ready=0. Raising m_r_ready[0] completes the handshake.
- Same-cycle AR load and R last for I$ at count 2 → outstanding[0] stays 2.
